// File: rtl/pipe_cla_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_cla_pkg
// Purpose  : Shared constants and helpers for the pipelined CLA adder:
//            CLA group size, opcode encodings and the signed-saturation
//            values (used only when PIPE_CLA_SAT_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
package pipe_cla_pkg;

   localparam int   CLA_GROUP = 4;
   localparam int   MAX_WIDTH = 128;
   localparam logic OP_ADD    = 1'b0;
   localparam logic OP_SUB    = 1'b1;

   // Most positive signed value of a w-bit word: 0x7F..F
   function automatic logic [MAX_WIDTH-1:0] sat_pos(input int w);
      logic [MAX_WIDTH-1:0] v;
      v = '0;
      for (int i = 0; i < MAX_WIDTH; i++) begin
         if (i < w - 1) v[i] = 1'b1;
      end
      return v;
   endfunction

   // Most negative signed value of a w-bit word: 0x80..0
   function automatic logic [MAX_WIDTH-1:0] sat_neg(input int w);
      logic [MAX_WIDTH-1:0] v;
      v = '0;
      for (int i = 0; i < MAX_WIDTH; i++) begin
         if (i == w - 1) v[i] = 1'b1;
      end
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cla_slice.sv
`default_nettype none
// ============================================================================
// Module   : cla_slice
// Purpose  : Combinational N-bit carry-lookahead adder. Carries inside each
//            4-bit group are formed as sum-of-products lookahead terms; the
//            group carry is passed group to group.
// Revision : 1.0 - initial release
// ============================================================================
module cla_slice
   import pipe_cla_pkg::*;
#(
   parameter int N = 16
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         c_msb
);

   localparam int NG = N / CLA_GROUP;

   logic [N-1:0] g;
   logic [N-1:0] p;
   logic [N:0]   c;

   assign g = a & b;
   assign p = a ^ b;

   // Lookahead carries: c[j] = G[j-1:0] | P[j-1:0]&cg within each group
   always_comb begin
      logic cg;
      logic t;
      logic term;
      c    = '0;
      cg   = cin;
      t    = 1'b0;
      term = 1'b0;
      c[0] = cin;
      for (int gi = 0; gi < NG; gi++) begin
         for (int j = 1; j <= CLA_GROUP; j++) begin
            t = cg;
            for (int k = 0; k < j; k++) t = t & p[gi*CLA_GROUP + k];
            for (int k = 0; k < j; k++) begin
               term = g[gi*CLA_GROUP + k];
               for (int m = k + 1; m < j; m++) term = term & p[gi*CLA_GROUP + m];
               t = t | term;
            end
            c[gi*CLA_GROUP + j] = t;
         end
         cg = t;
      end
   end

   assign sum   = p ^ c[N-1:0];
   assign cout  = c[N];
   assign c_msb = c[N-1];

endmodule
`default_nettype wire

// File: rtl/pipe_cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipe_cla_adder
// Purpose  : Pipelined add/subtract with STAGES carry-lookahead slices. Stage
//            k adds slice k and registers the slice carry; unconsumed operand
//            slices and finished sum slices travel along so a beat's result
//            leaves in one piece after STAGES cycles. Global stall on
//            out_valid & !out_ready.
//            Optional macro PIPE_CLA_SAT_EN enables signed saturation
//            requested per beat by in_sat.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_cla_adder
   import pipe_cla_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   input  logic             in_sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int SW   = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;
`ifdef PIPE_CLA_SAT_EN
   localparam logic [MAX_WIDTH-1:0] C_SAT_POS = sat_pos(WIDTH);
   localparam logic [MAX_WIDTH-1:0] C_SAT_NEG = sat_neg(WIDTH);
`endif

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             src_valid;
      logic [WIDTH-1:0] src_a;
      logic [WIDTH-1:0] src_b;
      logic             src_carry;
      logic [WIDTH-1:0] src_sum;
      logic             src_sat;
      logic [SW-1:0]    slice_sum;
      logic             slice_cout;
      logic             slice_cmsb;
      logic [WIDTH-1:0] sum_d;

      logic             valid_q;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic             carry_q;
      logic [WIDTH-1:0] sum_q;
      logic             sat_q;
      logic             ovf_q;

      if (k == 0) begin : g_src
         // Subtraction enters as A + ~B + 1; in_cin is ignored then
         assign src_valid = in_valid;
         assign src_a     = in_a;
         assign src_b     = (in_sub == OP_SUB) ? ~in_b : in_b;
         assign src_carry = (in_sub == OP_SUB) ? 1'b1 : in_cin;
         assign src_sum   = '0;
         assign src_sat   = in_sat;
      end else begin : g_src
         assign src_valid = g_stage[k-1].valid_q;
         assign src_a     = g_stage[k-1].a_q;
         assign src_b     = g_stage[k-1].b_q;
         assign src_carry = g_stage[k-1].carry_q;
         assign src_sum   = g_stage[k-1].sum_q;
         assign src_sat   = g_stage[k-1].sat_q;
      end

      cla_slice #(.N(SW)) u_slice (
         .a     (src_a[k*SW +: SW]),
         .b     (src_b[k*SW +: SW]),
         .cin   (src_carry),
         .sum   (slice_sum),
         .cout  (slice_cout),
         .c_msb (slice_cmsb)
      );

      // Merge this stage's slice into the partial sum; clamp at the last stage
      always_comb begin
         sum_d             = src_sum;
         sum_d[k*SW +: SW] = slice_sum;
`ifdef PIPE_CLA_SAT_EN
         if ((k == LAST) && src_sat && (slice_cmsb ^ slice_cout)) begin
            // carry into MSB without carry out means positive overflow
            sum_d = slice_cmsb ? C_SAT_POS[WIDTH-1:0] : C_SAT_NEG[WIDTH-1:0];
         end
`endif
      end

      // Stage register: advances only when the whole pipe is not stalled
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            sat_q   <= 1'b0;
            ovf_q   <= 1'b0;
         end else if (in_ready) begin
            valid_q <= src_valid;
            a_q     <= src_a;
            b_q     <= src_b;
            carry_q <= slice_cout;
            sum_q   <= sum_d;
            sat_q   <= src_sat;
            ovf_q   <= slice_cmsb ^ slice_cout;
         end
      end
   end

`ifndef PIPE_CLA_SAT_EN
   // Saturation request travels with the beat but has no effect here
   logic unused_sat;
   assign unused_sat = g_stage[LAST].sat_q;
`endif

   assign out_valid = g_stage[LAST].valid_q;
   assign out_sum   = g_stage[LAST].sum_q;
   assign out_cout  = g_stage[LAST].carry_q;
   assign out_ovf   = g_stage[LAST].ovf_q;
   assign in_ready  = !out_valid || out_ready;

endmodule
`default_nettype wire

// File: tb/tb_pipe_cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_cla_adder
// Purpose  : Self-checking bench for pipe_cla_adder (32/2 directed + stream,
//            64-bit STAGES=1/2/4 random against an arithmetic model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_cla_adder;

`ifdef PIPE_CLA_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   typedef struct {
      logic [63:0] s;
      logic        c;
      logic        o;
   } exp_t;

   logic clk;
   logic rst_n;

   // 32-bit, 2-stage DUT
   logic        t_valid, t_ready, t_cin, t_sub, t_sat, t_ovalid, t_oready, t_cout, t_ovf;
   logic [31:0] t_a, t_b, t_sum;

   // 64-bit DUTs share inputs
   logic        u_valid, u_cin, u_sub, u_sat, u_oready;
   logic [63:0] u_a, u_b;
   logic        o_ready [3];
   logic        o_v     [3];
   logic [63:0] o_s     [3];
   logic        o_c     [3];
   logic        o_o     [3];

   int errors = 0;
   int checks = 0;

   pipe_cla_adder #(.WIDTH(32), .STAGES(2)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(t_valid), .in_ready(t_ready),
      .in_a(t_a), .in_b(t_b), .in_cin(t_cin), .in_sub(t_sub), .in_sat(t_sat),
      .out_valid(t_ovalid), .out_ready(t_oready), .out_sum(t_sum),
      .out_cout(t_cout), .out_ovf(t_ovf));

   pipe_cla_adder #(.WIDTH(64), .STAGES(1)) dut64_1 (
      .clk(clk), .rst_n(rst_n), .in_valid(u_valid), .in_ready(o_ready[0]),
      .in_a(u_a), .in_b(u_b), .in_cin(u_cin), .in_sub(u_sub), .in_sat(u_sat),
      .out_valid(o_v[0]), .out_ready(u_oready), .out_sum(o_s[0]),
      .out_cout(o_c[0]), .out_ovf(o_o[0]));

   pipe_cla_adder #(.WIDTH(64), .STAGES(2)) dut64_2 (
      .clk(clk), .rst_n(rst_n), .in_valid(u_valid), .in_ready(o_ready[1]),
      .in_a(u_a), .in_b(u_b), .in_cin(u_cin), .in_sub(u_sub), .in_sat(u_sat),
      .out_valid(o_v[1]), .out_ready(u_oready), .out_sum(o_s[1]),
      .out_cout(o_c[1]), .out_ovf(o_o[1]));

   pipe_cla_adder #(.WIDTH(64), .STAGES(4)) dut64_4 (
      .clk(clk), .rst_n(rst_n), .in_valid(u_valid), .in_ready(o_ready[2]),
      .in_a(u_a), .in_b(u_b), .in_cin(u_cin), .in_sub(u_sub), .in_sat(u_sat),
      .out_valid(o_v[2]), .out_ready(u_oready), .out_sum(o_s[2]),
      .out_cout(o_c[2]), .out_ovf(o_o[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Arithmetic reference: w-bit two's-complement add/sub with optional clamp
   function automatic exp_t ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                    input logic cin, input logic sub, input logic sat);
      exp_t        r;
      logic [64:0] mask, aa, bb, full;
      mask = (65'd1 << w) - 65'd1;
      aa   = {1'b0, a} & mask;
      bb   = sub ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
      full = aa + bb + (sub ? 65'd1 : {64'd0, cin});
      r.s  = full[63:0] & mask[63:0];
      r.c  = full[w];
      r.o  = (aa[w-1] == bb[w-1]) && (r.s[w-1] != aa[w-1]);
      if (SAT_EN && sat && r.o)
         r.s = aa[w-1] ? (64'd1 << (w - 1)) : ((64'd1 << (w - 1)) - 64'd1);
      return r;
   endfunction

   // One isolated beat on the 32-bit DUT with exact 2-cycle latency check
   task automatic send_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub, input logic sat,
                           input logic [31:0] es, input logic ec, input logic eo);
      t_a = a; t_b = b; t_cin = cin; t_sub = sub; t_sat = sat; t_valid = 1'b1;
      #1;
      chk({tag, "_ready"}, 64'(t_ready), 64'd1);
      step();
      t_valid = 1'b0;
      chk({tag, "_valid_c1"}, 64'(t_ovalid), 64'd0);
      step();
      chk({tag, "_valid_c2"}, 64'(t_ovalid), 64'd1);
      chk({tag, "_sum"},  64'(t_sum),  64'(es));
      chk({tag, "_cout"}, 64'(t_cout), 64'(ec));
      chk({tag, "_ovf"},  64'(t_ovf),  64'(eo));
      step();
   endtask

   exp_t        q[$];
   exp_t        e;
   exp_t        hist [256];
   logic        hv   [256];
   logic [31:0] sa [8];
   logic [31:0] sb [8];
   logic        ss [8];
   int          lat [3];

   initial begin
      lat[0] = 1; lat[1] = 2; lat[2] = 4;
      rst_n = 1'b0;
      t_valid = 0; t_a = 0; t_b = 0; t_cin = 0; t_sub = 0; t_sat = 0; t_oready = 1;
      u_valid = 0; u_a = 0; u_b = 0; u_cin = 0; u_sub = 0; u_sat = 0; u_oready = 1;
      #2;
      chk("rst_out_valid", 64'(t_ovalid), 64'd0);
      chk("rst_out_sum",   64'(t_sum),    64'd0);
      chk("rst_out_cout",  64'(t_cout),   64'd0);
      chk("rst_out_ovf",   64'(t_ovf),    64'd0);
      chk("rst_64_valid",  64'(o_v[2]),   64'd0);
      step();
      rst_n = 1'b1;
      chk("rst_in_ready", 64'(t_ready), 64'd1);
      step();

      send_one("wrap",    32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      send_one("sat_pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1,
               SAT_EN ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1);
      send_one("sat_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1,
               SAT_EN ? 32'h8000_0000 : 32'h0, 1'b1, 1'b1);
      send_one("sub_neg", 32'd5, 32'd7, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
      send_one("sub_pos", 32'd7, 32'd5, 1'b0, 1'b1, 1'b0, 32'd2, 1'b1, 1'b0);
      send_one("add_cin", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 32'h2345_678A, 1'b0, 1'b0);

      // 8-beat stream, alternating add/sub, out_ready low for 3 cycles
      for (int i = 0; i < 8; i++) begin
         sa[i] = $urandom; sb[i] = $urandom; ss[i] = i[0];
      end
      begin
         int bi;
         int got;
         int cyc;
         bi = 0; got = 0; cyc = 0;
         while (got < 8 && cyc < 60) begin
            t_oready = !(cyc >= 4 && cyc <= 6);
            if (bi < 8) begin
               t_valid = 1'b1; t_a = sa[bi]; t_b = sb[bi]; t_cin = 1'b0; t_sub = ss[bi]; t_sat = 1'b0;
            end else begin
               t_valid = 1'b0;
            end
            #1;
            if (t_ovalid && !t_oready) chk("stall_in_ready", 64'(t_ready), 64'd0);
            if (t_ovalid) begin
               chk("stream_pending", 64'(q.size() > 0), 64'd1);
               if (q.size() > 0) begin
                  chk("stream_sum",  64'(t_sum),  q[0].s);
                  chk("stream_cout", 64'(t_cout), 64'(q[0].c));
                  chk("stream_ovf",  64'(t_ovf),  64'(q[0].o));
                  if (t_oready) begin
                     void'(q.pop_front());
                     got++;
                  end
               end
            end
            if (t_valid && t_ready) begin
               q.push_back(ref_add(32, 64'(sa[bi]), 64'(sb[bi]), 1'b0, ss[bi], 1'b0));
               bi++;
            end
            @(posedge clk);
            #1;
            cyc++;
         end
         chk("stream_count", 64'(got), 64'd8);
         chk("stream_left",  64'(q.size()), 64'd0);
      end
      t_valid = 1'b0; t_oready = 1'b1;
      step();
      step();

      // Reset with two beats in flight
      t_a = 32'd100; t_b = 32'd1; t_sub = 0; t_cin = 0; t_valid = 1'b1;
      step();
      t_a = 32'd200;
      step();
      t_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(t_ovalid), 64'd0);
      chk("midrst_out_sum",   64'(t_sum),    64'd0);
      step();
      rst_n = 1'b1;
      chk("postrst_in_ready",  64'(t_ready),  64'd1);
      chk("postrst_out_valid", 64'(t_ovalid), 64'd0);
      step();
      chk("postrst_flushed", 64'(t_ovalid), 64'd0);
      send_one("postrst", 32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);

      // 64-bit random comparison at STAGES = 1, 2, 4
      for (int cyc = 0; cyc < 200; cyc++) begin
         u_valid = ($urandom_range(0, 3) != 0);
         u_a     = {$urandom, $urandom};
         u_b     = {$urandom, $urandom};
         u_cin   = $urandom_range(0, 1);
         u_sub   = $urandom_range(0, 1);
         u_sat   = $urandom_range(0, 1);
         if ($urandom_range(0, 7) == 0) u_a[63] = ~u_b[63] ^ u_sub;
         #1;
         hv[cyc]   = u_valid;
         hist[cyc] = ref_add(64, u_a, u_b, u_cin, u_sub, u_sat);
         for (int d = 0; d < 3; d++) begin
            if (cyc >= lat[d]) begin
               chk($sformatf("r64_s%0d_valid", lat[d]), 64'(o_v[d]), 64'(hv[cyc-lat[d]]));
               if (hv[cyc-lat[d]]) begin
                  e = hist[cyc-lat[d]];
                  chk($sformatf("r64_s%0d_sum", lat[d]),  o_s[d],       e.s);
                  chk($sformatf("r64_s%0d_cout", lat[d]), 64'(o_c[d]), 64'(e.c));
                  chk($sformatf("r64_s%0d_ovf", lat[d]),  64'(o_o[d]), 64'(e.o));
               end
            end else begin
               chk($sformatf("r64_s%0d_fill", lat[d]), 64'(o_v[d]), 64'd0);
            end
         end
         step();
      end
      u_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width; multiple of 16, range 16..128.
REQ-002 SHALL have parameter STAGES, default 2: pipeline depth; 1..WIDTH/16, and WIDTH/16 divisible by STAGES.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operand beat valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts a beat this cycle.
REQ-007 SHALL have port in_a, input, WIDTH bits: operand A.
REQ-008 SHALL have port in_b, input, WIDTH bits: operand B.
REQ-009 SHALL have port in_cin, input, 1 bit: carry-in; ignored when in_sub=1.
REQ-010 SHALL have port in_sub, input, 1 bit: 0 = A+B+cin, 1 = A-B (A + ~B + 1).
REQ-011 SHALL have port in_sat, input, 1 bit: request signed saturation (see Configuration).
REQ-012 SHALL have port out_valid, output, 1 bit: result valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-014 SHALL have port out_sum, output, WIDTH bits: result.
REQ-015 SHALL have port out_cout, output, 1 bit: carry-out of the MSB; for subtraction 1 = no borrow.
REQ-016 SHALL have port out_ovf, output, 1 bit: signed two's-complement overflow of the unsaturated result.

Function
REQ-017 SHALL split operands into STAGES equal slices of WIDTH/STAGES bits; stage k computes slice k (LSB slice first) with carry-lookahead in 4-bit groups.
REQ-018 SHALL register the inter-slice carry between stages; operand slices not yet consumed are delayed and completed sum slices skew-aligned, so all result bits of one beat emerge together.
REQ-019 SHALL have a latency of exactly STAGES cycles from accepted beat (in_valid & in_ready) to out_valid with no stall; throughput of one beat per cycle.
REQ-020 SHALL drive in_ready = !out_valid | out_ready (global stall); when stalled, all stage registers hold.
REQ-021 SHALL hold out_sum/out_cout/out_ovf stable while out_valid=1 and out_ready=0.
REQ-022 SHALL propagate bubbles: a stage with no valid beat advances as empty; out_valid deasserts when no beat is in the final stage.
REQ-023 SHALL compute out_ovf = carry into MSB XOR carry out of MSB.
REQ-024 SHALL give beats order-preserving, independent results; back-to-back add/sub mixes require no dead cycle.
REQ-025 SHALL treat simultaneous accept and output-complete in one cycle as a normal pipeline advance, with no loss or duplication.

Reset
REQ-026 SHALL clear all stage-valid flags, out_valid, out_sum, out_cout and out_ovf to 0 immediately on rst_n=0, independent of clk.
REQ-027 SHALL discard in-flight beats on reset mid-operation; in_ready=1 in the first cycle after release.

Configuration
REQ-028 With macro PIPE_CLA_SAT_EN defined, SHALL clamp out_sum on overflow when in_sat=1 (carried with the beat): positive overflow yields 0x7F..F and negative overflow yields 0x80..0; out_ovf still reports the overflow.
REQ-029 Without PIPE_CLA_SAT_EN, in_sat SHALL remain a port but be ignored, and out_sum always wraps.

Structure
REQ-030 Package pipe_cla_pkg SHALL hold CLA_GROUP=4, the saturation constants as WIDTH-parameterised functions, and the opcode localparams OP_ADD=0 and OP_SUB=1.
REQ-031 SHALL use one sub-module, cla_slice: a combinational N-bit CLA with inputs a, b and cin, and outputs sum, cout and c_msb (carry into the MSB); one instance per stage.

Verification
REQ-032 SHALL cover, with WIDTH=32 and STAGES=2: A=0xFFFFFFFF, B=0x00000001, cin=0, add -> sum=0x00000000, cout=1, ovf=0, out_valid exactly 2 cycles after accept.
REQ-033 SHALL cover: A=0x7FFFFFFF, B=1, add, in_sat=1 -> with the macro sum=0x7FFFFFFF and ovf=1; without the macro sum=0x80000000 and ovf=1.
REQ-034 SHALL cover: A=5, B=7, sub -> sum=0xFFFFFFFE, cout=0, ovf=0; then A=7, B=5, sub -> sum=2, cout=1.
REQ-035 SHALL cover a stream of 8 beats with out_ready low for 3 cycles mid-stream -> in_ready low during the stall, outputs held stable, all 8 results in order, none lost or duplicated.
REQ-036 SHALL cover reset asserted with 2 beats in flight -> out_valid=0 immediately; the first post-reset beat produces the correct result after 2 cycles.
REQ-037 SHALL cover WIDTH=64 with STAGES=1, 2 and 4 against random operands vs a reference model, with latency equal to STAGES.
